// File: rtl/aemb2_div_pkg.sv
// aemb2_div_pkg: shared state encoding and constants for the AEMB2 iterative divider
package aemb2_div_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIN} div_state_t;
  localparam int CNT_W = 5;
  localparam logic [31:0] DIV_OVF = 32'h8000_0000;
endpackage

// File: rtl/aemb2_div_if.sv
// aemb2_div_if: execute-stage to divider handshake bundle
interface aemb2_div_if;
  logic div_stb;
  logic div_sgn;
  logic [31:0] opa_of;
  logic [31:0] opb_of;
  logic [31:0] div_mx;
  logic div_ack;
  logic div_bsy;
  logic div_dbz;
  modport master(output div_stb, div_sgn, opa_of, opb_of, input div_mx, div_ack, div_bsy, div_dbz);
  modport slave(input div_stb, div_sgn, opa_of, opb_of, output div_mx, div_ack, div_bsy, div_dbz);
endinterface

// File: rtl/aemb2_div_step.sv
// aemb2_div_step: one combinational restoring-division iteration
module aemb2_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvs,
  output logic [31:0] rem_n,
  output logic [31:0] quo_n
);
  // 33 bits: the shifted remainder can exceed 32 bits when dvs > 2^31
  logic [32:0] sh, trial;
  assign sh = {rem, quo[31]};
  assign trial = sh - {1'b0, dvs};
  assign rem_n = trial[32] ? sh[31:0] : trial[31:0];
  assign quo_n = {quo[30:0], ~trial[32]};
endmodule

// File: rtl/aemb2_div.sv
// aemb2_div: iterative radix-2 restoring divider (quotient = opb_of / opa_of), 33-cycle latency.
// AEMB2_DIV_SIGNED_EN enables signed idiv via div_sgn; otherwise every operation is unsigned.
module aemb2_div
  import aemb2_div_pkg::*;
#(
  parameter bit AEMB_DIV = 1'b1,
  parameter int DW = 32
) (
  input logic gclk,
  input logic grst,
  input logic dena,
  aemb2_div_if.slave d
);
  if (AEMB_DIV) begin : g_div
    div_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0] rem, rem_n, quo, quo_n, dvs, dvs_n, mx, mx_n;
    logic [31:0] stp_rem, stp_quo, abs_a, abs_b, res;
    logic dbz, dbz_n, ack, ack_n;
`ifdef AEMB2_DIV_SIGNED_EN
    logic neg;
    assign abs_a = (d.div_sgn && d.opa_of[31]) ? -d.opa_of : d.opa_of;
    assign abs_b = (d.div_sgn && d.opb_of[31]) ? -d.opb_of : d.opb_of;
    assign res = neg ? -quo : quo;
    always_ff @(posedge gclk)
      if (grst) neg <= 1'b0;
      else if (dena && state == DIV_IDLE && d.div_stb) neg <= d.div_sgn & (d.opa_of[31] ^ d.opb_of[31]);
`else
    assign abs_a = d.opa_of;
    assign abs_b = d.opb_of;
    assign res = quo;
`endif
    aemb2_div_step u_step (.rem(rem), .quo(quo), .dvs(dvs), .rem_n(stp_rem), .quo_n(stp_quo));
    always_comb begin
      state_n = state;
      cnt_n = cnt;
      rem_n = rem;
      quo_n = quo;
      dvs_n = dvs;
      mx_n = mx;
      dbz_n = dbz;
      ack_n = 1'b0;
      case (state)
        DIV_IDLE: if (d.div_stb) begin
          state_n = (d.opa_of == '0) ? DIV_FIN : DIV_CALC;
          dbz_n = d.opa_of == '0;
          rem_n = '0;
          quo_n = abs_b;
          dvs_n = abs_a;
          cnt_n = CNT_W'(DW - 1);
        end
        DIV_CALC: begin
          rem_n = stp_rem;
          quo_n = stp_quo;
          cnt_n = cnt - 1'b1;
          state_n = (cnt == '0) ? DIV_FIN : DIV_CALC;
        end
        DIV_FIN: begin
          mx_n = dbz ? '0 : res;
          ack_n = 1'b1;
          state_n = DIV_IDLE;
        end
        default: state_n = DIV_IDLE;
      endcase
    end
    always_ff @(posedge gclk)
      if (grst) begin
        state <= DIV_IDLE;
        cnt <= '0;
        rem <= '0;
        quo <= '0;
        dvs <= '0;
        mx <= '0;
        dbz <= 1'b0;
        ack <= 1'b0;
      end else if (dena) begin
        state <= state_n;
        cnt <= cnt_n;
        rem <= rem_n;
        quo <= quo_n;
        dvs <= dvs_n;
        mx <= mx_n;
        dbz <= dbz_n;
        ack <= ack_n;
      end
    assign d.div_mx = mx;
    assign d.div_ack = ack;
    assign d.div_bsy = state != DIV_IDLE;
    assign d.div_dbz = dbz & ack;
  end else begin : g_nodiv
    assign d.div_mx = '0;
    assign d.div_ack = 1'b0;
    assign d.div_bsy = 1'b0;
    assign d.div_dbz = 1'b0;
  end
endmodule

// File: tb/tb_aemb2_div.sv
// tb_aemb2_div: vector table plus scoreboard checks of the AEMB2 divider, including dena stall and reset abort.
module tb_aemb2_div;
  import aemb2_div_pkg::*;
`ifdef AEMB2_DIV_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif
  typedef struct {logic sgn; logic [31:0] a; logic [31:0] b; logic [31:0] mx; logic dbz; int lat;} vec_t;
  typedef struct {logic [31:0] mx; logic dbz; int lat;} exp_t;
  logic gclk = 1'b0, grst = 1'b1, dena = 1'b1;
  logic ack_d = 1'b0;
  int passed = 0, total = 0, acks = 0;
  vec_t tv[13];
  exp_t sb[$];
  aemb2_div_if bus();
  aemb2_div dut (.gclk(gclk), .grst(grst), .dena(dena), .d(bus));
  always #5 gclk = ~gclk;
  always @(negedge gclk) begin
    if (bus.div_ack === 1'b1 && !ack_d) acks++;
    ack_d <= bus.div_ack;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge gclk);
    #1;
  endtask
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.div_stb = 1'b1;
    bus.div_sgn = s;
    bus.opa_of = a;
    bus.opb_of = b;
    tick();
    bus.div_stb = 1'b0;
  endtask
  task automatic wait_ack(input string nm, input int pre);
    exp_t e;
    int c;
    c = pre;
    while (bus.div_ack !== 1'b1 && c < pre + 200) begin
      tick();
      c++;
    end
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: ack with no queued expectation", nm);
      return;
    end
    e = sb.pop_front();
    if (bus.div_ack !== 1'b1) begin
      total++;
      $display("FAIL %s timeout: no div_ack after %0d cycles, expected at %0d", nm, c, e.lat);
      return;
    end
    chk({nm, " latency"}, c, e.lat);
    chk({nm, " div_mx"}, bus.div_mx, e.mx);
    chk({nm, " div_dbz"}, {31'd0, bus.div_dbz}, {31'd0, e.dbz});
    chk({nm, " div_bsy at ack"}, {31'd0, bus.div_bsy}, 32'd0);
    tick();
    chk({nm, " ack one cycle"}, {31'd0, bus.div_ack}, 32'd0);
  endtask
  initial begin
    int a0;
    tv[0] = '{1'b0, 32'd7, 32'd100, 32'h0000000E, 1'b0, 33};
    tv[1] = '{1'b1, 32'd7, 32'hFFFFFF9C, SG ? 32'hFFFFFFF2 : 32'h24924916, 1'b0, 33};
    tv[2] = '{1'b1, 32'hFFFFFFF9, 32'd100, SG ? 32'hFFFFFFF2 : 32'h0, 1'b0, 33};
    tv[3] = '{1'b0, 32'd0, 32'h1234, 32'h0, 1'b1, 1};
    tv[4] = '{1'b0, 32'd3, 32'd9, 32'd3, 1'b0, 33};
    tv[5] = '{1'b1, 32'hFFFFFFFF, DIV_OVF, SG ? DIV_OVF : 32'h0, 1'b0, 33};
    tv[6] = '{1'b0, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33};
    tv[7] = '{1'b0, 32'd5, 32'd0, 32'd0, 1'b0, 33};
    tv[8] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 33};
    tv[9] = '{1'b0, 32'h80000001, 32'hFFFFFFFF, 32'd1, 1'b0, 33};
    tv[10] = '{1'b1, 32'hFFFFFFFE, 32'hFFFFFFF9, SG ? 32'd3 : 32'd0, 1'b0, 33};
    tv[11] = '{1'b1, 32'd0, 32'd5, 32'd0, 1'b1, 1};
    tv[12] = '{1'b0, 32'd7, 32'hFFFFFF9C, 32'h24924916, 1'b0, 33};
    bus.div_stb = 1'b0;
    bus.div_sgn = 1'b0;
    bus.opa_of = '0;
    bus.opb_of = '0;
    repeat (3) tick();
    chk("reset div_mx", bus.div_mx, 32'd0);
    chk("reset div_ack", {31'd0, bus.div_ack}, 32'd0);
    chk("reset div_bsy", {31'd0, bus.div_bsy}, 32'd0);
    chk("reset div_dbz", {31'd0, bus.div_dbz}, 32'd0);
    grst = 1'b0;
    tick();
    for (int i = 0; i < 13; i++) begin
      sb.push_back('{tv[i].mx, tv[i].dbz, tv[i].lat});
      start_op(tv[i].sgn, tv[i].a, tv[i].b);
      if (!tv[i].dbz) chk($sformatf("v%0d div_bsy", i), {31'd0, bus.div_bsy}, 32'd1);
      wait_ack($sformatf("v%0d", i), 0);
      tick();
    end
    a0 = acks;
    sb.push_back('{32'd100, 1'b0, 38});
    start_op(1'b0, 32'd10, 32'd1000);
    repeat (10) tick();
    dena = 1'b0;
    repeat (5) tick();
    dena = 1'b1;
    start_op(1'b0, 32'd1, 32'd1);
    wait_ack("stall", 16);
    repeat (40) tick();
    chk("stall single ack", acks - a0, 32'd1);
    a0 = acks;
    start_op(1'b0, 32'd5, 32'd50);
    repeat (9) tick();
    grst = 1'b1;
    tick();
    grst = 1'b0;
    chk("abort div_mx", bus.div_mx, 32'd0);
    chk("abort div_ack", {31'd0, bus.div_ack}, 32'd0);
    chk("abort div_bsy", {31'd0, bus.div_bsy}, 32'd0);
    chk("abort div_dbz", {31'd0, bus.div_dbz}, 32'd0);
    repeat (40) tick();
    chk("abort no ack", acks - a0, 32'd0);
    sb.push_back('{32'd10, 1'b0, 33});
    start_op(1'b0, 32'd5, 32'd50);
    wait_ack("post-reset", 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
